// File: rtl/wb_xbar_timeout_if.sv
// Master-side Wishbone bus between the Caravel master and the xbar router.
interface wb_xbar_timeout_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_xbar_timeout.sv
// Registered Wishbone router: decodes the master address onto one of the team
// wrappers, LA control or GPIO control, waits for that target's ack and aborts
// a stalled target with a watchdog that returns ERR_DATA and an error pulse.
module wb_xbar_timeout #(
  parameter int          NUM_TEAMS   = 1,
  parameter logic [7:0]  BASE_HI     = 8'h30,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hBADC0DE0
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  wb_xbar_timeout_if.slave            wbs,
  output logic [NUM_TEAMS:0]          designs_stb,
  output logic                        la_control_stb,
  output logic                        gpio_control_stb,
  output logic [31:0]                 adr_truncated,
  input  logic [NUM_TEAMS:0]          designs_ack_o,
  input  logic [32*(NUM_TEAMS+1)-1:0] designs_dat_flat,
  input  logic                        la_control_ack_o,
  input  logic [31:0]                 la_control_dat_o,
  input  logic                        gpio_control_ack_o,
  input  logic [31:0]                 gpio_control_dat_o,
  output logic                        err_irq,
  output logic [7:0]                  err_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [7:0]  SEL_LA   = 8'hFE;
  localparam logic [7:0]  SEL_GPIO = 8'hFF;
  localparam logic [7:0]  TEAM_MAX = 8'(NUM_TEAMS);
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYC - 1);

  state_e               state_q, state_d;
  logic [7:0]           tgt_q, tgt_d;
  logic [15:0]          adr_q, adr_d;
  logic [15:0]          wd_q, wd_d;
  logic                 err_q, err_d;
  logic [31:0]          cap_q, cap_d;
  logic [NUM_TEAMS:0]   dstb_q, dstb_d;
  logic                 la_stb_q, la_stb_d;
  logic                 gpio_stb_q, gpio_stb_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic                 irq_q, irq_d;
  logic [7:0]           cnt_q, cnt_d;

  logic [7:0]  sel;
  logic        hit_team, hit_la, hit_gpio, dec_ok, req;
  logic        t_ack;
  logic [31:0] t_dat;

  // Team slot 0 is reserved, so its ack and data lanes are never looked at.
  logic unused_team0;
  assign unused_team0 = designs_ack_o[0] ^ (^designs_dat_flat[31:0]);

  // Address decode of the incoming request and ack/data select for the latched target.
  always_comb begin
    sel      = wbs.wbs_adr_i[23:16];
    hit_team = (sel >= 8'd1) && (sel <= TEAM_MAX);
    hit_la   = (sel == SEL_LA);
    hit_gpio = (sel == SEL_GPIO);
    dec_ok   = (wbs.wbs_adr_i[31:24] == BASE_HI) && (hit_team || hit_la || hit_gpio);
    req      = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_q;
    t_ack    = 1'b0;
    t_dat    = 32'h0;
    for (int i = 1; i <= NUM_TEAMS; i++) begin
      if (tgt_q == 8'(i)) begin
        t_ack = designs_ack_o[i];
        t_dat = designs_dat_flat[32*i +: 32];
      end
    end
    if (tgt_q == SEL_LA) begin
      t_ack = la_control_ack_o;
      t_dat = la_control_dat_o;
    end
    if (tgt_q == SEL_GPIO) begin
      t_ack = gpio_control_ack_o;
      t_dat = gpio_control_dat_o;
    end
  end

  // Transfer FSM: accept in IDLE, hold one strobe in WAIT, respond for one cycle in RESP.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    adr_d      = adr_q;
    wd_d       = wd_q;
    err_d      = err_q;
    cap_d      = cap_q;
    dstb_d     = dstb_q;
    la_stb_d   = la_stb_q;
    gpio_stb_d = gpio_stb_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    dat_d      = 32'h0;
    irq_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          tgt_d = sel;
          adr_d = wbs.wbs_adr_i[15:0];
          wd_d  = 16'h0;
          cap_d = 32'h0;
          if (dec_ok) begin
            state_d = WAIT;
            err_d   = 1'b0;
            dstb_d  = '0;
            for (int i = 1; i <= NUM_TEAMS; i++) begin
              dstb_d[i] = (sel == 8'(i));
            end
            la_stb_d   = hit_la;
            gpio_stb_d = hit_gpio;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!wbs.wbs_cyc_i) begin
          state_d    = IDLE;
          dstb_d     = '0;
          la_stb_d   = 1'b0;
          gpio_stb_d = 1'b0;
        end else if (t_ack) begin
          state_d    = RESP;
          cap_d      = t_dat;
          err_d      = 1'b0;
          dstb_d     = '0;
          la_stb_d   = 1'b0;
          gpio_stb_d = 1'b0;
        end else if (wd_q == WD_LAST) begin
          state_d    = RESP;
          err_d      = 1'b1;
          dstb_d     = '0;
          la_stb_d   = 1'b0;
          gpio_stb_d = 1'b0;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        ack_d   = 1'b1;
        dat_d   = err_q ? ERR_DATA : cap_q;
        irq_d   = err_q;
        if (err_q && (cnt_q != 8'hFF)) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops every strobe and the ack immediately.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= IDLE;
      tgt_q      <= 8'h0;
      adr_q      <= 16'h0;
      wd_q       <= 16'h0;
      err_q      <= 1'b0;
      cap_q      <= 32'h0;
      dstb_q     <= '0;
      la_stb_q   <= 1'b0;
      gpio_stb_q <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      irq_q      <= 1'b0;
      cnt_q      <= 8'h0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      adr_q      <= adr_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      cap_q      <= cap_d;
      dstb_q     <= dstb_d;
      la_stb_q   <= la_stb_d;
      gpio_stb_q <= gpio_stb_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wbs.wbs_ack_o    = ack_q;
  assign wbs.wbs_dat_o    = dat_q;
  assign designs_stb      = dstb_q;
  assign la_control_stb   = la_stb_q;
  assign gpio_control_stb = gpio_stb_q;
  assign adr_truncated    = {16'h0, adr_q};
  assign err_irq          = irq_q;
  assign err_count        = cnt_q;

endmodule

// File: tb/tb_wb_xbar_timeout.sv
// Bench for wb_xbar_timeout: directed reads with hand-computed responses pushed
// into a scoreboard queue, a monitor that checks every ack, and target models
// that ack a programmable number of cycles after their strobe rises.
module tb_wb_xbar_timeout;

  localparam int          NT     = 2;
  localparam int          TO     = 4;
  localparam logic [31:0] ERRD   = 32'hBADC0DE0;
  localparam logic [31:0] TEAM1_D = 32'h0000_1234;
  localparam logic [31:0] TEAM2_D = 32'h2222_0002;
  localparam logic [31:0] LA_D    = 32'h00AA_0011;
  localparam logic [31:0] GPIO_D  = 32'h0000_0055;
  localparam logic [31:0] NOISE_D = 32'hDEAD_BEEF;

  // all_stb bit positions: 1 team1, 2 team2, 3 LA, 4 GPIO
  localparam logic [4:0] M_T1   = 5'b00010;
  localparam logic [4:0] M_T2   = 5'b00100;
  localparam logic [4:0] M_LA   = 5'b01000;
  localparam logic [4:0] M_GPIO = 5'b10000;

  typedef struct {
    logic [31:0] dat;
    logic        irq;
    logic [7:0]  cnt;
    int          lat;
    int          issue;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  wb_xbar_timeout_if wbs_if();

  logic [NT:0]          designs_stb;
  logic                 la_stb, gpio_stb;
  logic [31:0]          adr_trunc;
  logic [NT:0]          team_ack;
  logic [32*(NT+1)-1:0] team_dat;
  logic                 la_ack, gpio_ack;
  logic [31:0]          la_dat, gpio_dat;
  logic                 err_irq;
  logic [7:0]           err_count;
  logic [4:0]           all_stb;

  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  int   exp_cnt = 0;
  exp_t sb_q[$];
  int   delay [1:4] = '{-1, -1, -1, -1};
  int   scnt  [1:4] = '{0, 0, 0, 0};
  bit   noise = 1'b0;

  assign all_stb = {gpio_stb, la_stb, designs_stb};

  always #5 clk = ~clk;

  wb_xbar_timeout #(
    .NUM_TEAMS   (NT),
    .BASE_HI     (8'h30),
    .TIMEOUT_CYC (TO),
    .ERR_DATA    (ERRD)
  ) dut (
    .wb_clk_i           (clk),
    .wb_rst_ni          (rst_n),
    .wbs                (wbs_if.slave),
    .designs_stb        (designs_stb),
    .la_control_stb     (la_stb),
    .gpio_control_stb   (gpio_stb),
    .adr_truncated      (adr_trunc),
    .designs_ack_o      (team_ack),
    .designs_dat_flat   (team_dat),
    .la_control_ack_o   (la_ack),
    .la_control_dat_o   (la_dat),
    .gpio_control_ack_o (gpio_ack),
    .gpio_control_dat_o (gpio_dat),
    .err_irq            (err_irq),
    .err_count          (err_count)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit target_acks(input int t);
    return (delay[t] >= 0) && all_stb[t] && (scnt[t] - 1 == delay[t]);
  endfunction

  // Cycle counter used for latency measurement.
  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Target models: ack for one cycle, delay[t] cycles after the strobe rises.
  initial begin
    team_ack = '0;
    team_dat = '0;
    la_ack   = 1'b0;
    la_dat   = 32'h0;
    gpio_ack = 1'b0;
    gpio_dat = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      for (int t = 1; t <= 4; t++) begin
        if (all_stb[t]) scnt[t]++;
        else            scnt[t] = 0;
      end
      team_ack[0] = noise;
      team_ack[1] = target_acks(1);
      team_ack[2] = target_acks(2);
      team_dat    = {target_acks(2) ? TEAM2_D : 32'h0,
                     target_acks(1) ? TEAM1_D : 32'h0,
                     noise ? NOISE_D : 32'h0};
      la_ack      = target_acks(3) | noise;
      la_dat      = target_acks(3) ? LA_D : (noise ? NOISE_D : 32'h0);
      gpio_ack    = target_acks(4);
      gpio_dat    = target_acks(4) ? GPIO_D : 32'h0;
    end
  end

  // Monitor: every ack is matched against the oldest expected response.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (wbs_if.wbs_ack_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ack: got ack with dat %h, expected no ack", wbs_if.wbs_dat_o);
      end else begin
        e = sb_q.pop_front();
        check_output("resp_dat", wbs_if.wbs_dat_o, e.dat);
        check_output("resp_irq", 32'(err_irq), 32'(e.irq));
        check_output("resp_err_count", 32'(err_count), 32'(e.cnt));
        check_output("resp_latency", 32'(cyc_n - e.issue), 32'(e.lat));
      end
    end else begin
      check_output("idle_dat", wbs_if.wbs_dat_o, 32'h0);
      check_output("stray_irq", 32'(err_irq), 32'h0);
    end
  end

  // One read: push the expected response, watch strobes, release on ack.
  task automatic apply_stimulus(input logic [31:0] adr, input logic [4:0] exp_mask,
                                input int exp_stb_cyc, input logic [31:0] exp_dat,
                                input bit exp_err, input int exp_lat);
    exp_t e;
    int   stb_cyc = 0;
    bit   got = 1'b0;
    @(negedge clk);
    wbs_if.wbs_cyc_i = 1'b1;
    wbs_if.wbs_stb_i = 1'b1;
    wbs_if.wbs_adr_i = adr;
    if (exp_err && exp_cnt != 255) exp_cnt++;
    e.dat   = exp_err ? ERRD : exp_dat;
    e.irq   = exp_err;
    e.cnt   = 8'(exp_cnt);
    e.lat   = exp_lat;
    e.issue = cyc_n + 1;
    sb_q.push_back(e);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (all_stb != 5'b0) begin
        stb_cyc++;
        check_output("strobe_select", 32'(all_stb), 32'(exp_mask));
      end
      if (wbs_if.wbs_ack_o === 1'b1) got = 1'b1;
    end
    check_output("ack_seen", 32'(got), 32'd1);
    if (got) check_output("adr_truncated", adr_trunc, {16'h0, adr[15:0]});
    wbs_if.wbs_cyc_i = 1'b0;
    wbs_if.wbs_stb_i = 1'b0;
    check_output("strobe_cycles", 32'(stb_cyc), 32'(exp_stb_cyc));
  endtask

  initial begin
    wbs_if.wbs_cyc_i = 1'b0;
    wbs_if.wbs_stb_i = 1'b0;
    wbs_if.wbs_adr_i = 32'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    check_output("rst_ack", 32'(wbs_if.wbs_ack_o), 32'h0);
    check_output("rst_dat", wbs_if.wbs_dat_o, 32'h0);
    check_output("rst_strobes", 32'(all_stb), 32'h0);
    check_output("rst_adr_truncated", adr_trunc, 32'h0);
    check_output("rst_irq", 32'(err_irq), 32'h0);
    check_output("rst_err_count", 32'(err_count), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] team, GPIO, LA reads and decode errors");
    delay[1] = 1;
    apply_stimulus(32'h3001_0004, M_T1, 2, TEAM1_D, 1'b0, 3);
    delay[4] = 0;
    apply_stimulus(32'h30FF_0000, M_GPIO, 1, GPIO_D, 1'b0, 2);
    apply_stimulus(32'h3080_0000, 5'b0, 0, 32'h0, 1'b1, 1);
    apply_stimulus(32'h3101_0000, 5'b0, 0, 32'h0, 1'b1, 1);
    apply_stimulus(32'h3000_0008, 5'b0, 0, 32'h0, 1'b1, 1);
    apply_stimulus(32'h3003_0000, 5'b0, 0, 32'h0, 1'b1, 1);
    delay[3] = 2;
    apply_stimulus(32'h30FE_1234, M_LA, 3, LA_D, 1'b0, 4);

    $display("[TB] non-selected acks ignored");
    delay[2] = 2;
    noise    = 1'b1;
    apply_stimulus(32'h3002_ABCD, M_T2, 3, TEAM2_D, 1'b0, 4);
    noise    = 1'b0;

    $display("[TB] watchdog timeout and ack on the timeout cycle");
    delay[1] = -1;
    apply_stimulus(32'h3001_0010, M_T1, TO, 32'h0, 1'b1, TO + 1);
    delay[1] = TO - 1;
    apply_stimulus(32'h3001_0020, M_T1, TO, TEAM1_D, 1'b0, TO + 1);

    $display("[TB] master abort in WAIT");
    delay[2] = -1;
    @(negedge clk);
    wbs_if.wbs_cyc_i = 1'b1;
    wbs_if.wbs_stb_i = 1'b1;
    wbs_if.wbs_adr_i = 32'h3002_0000;
    @(negedge clk);
    check_output("abort_strobe_before", 32'(all_stb), 32'(M_T2));
    wbs_if.wbs_cyc_i = 1'b0;
    wbs_if.wbs_stb_i = 1'b0;
    @(negedge clk);
    check_output("abort_strobe_after", 32'(all_stb), 32'h0);
    repeat (6) @(negedge clk);
    delay[4] = 0;
    apply_stimulus(32'h30FF_0040, M_GPIO, 1, GPIO_D, 1'b0, 2);

    $display("[TB] error counter saturation");
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(32'h3000_0000 | (32'(i) << 24 & 32'h0100_0000) | 32'h0080_0000,
                     5'b0, 0, 32'h0, 1'b1, 1);
    end
    check_output("err_count_saturated", 32'(err_count), 32'hFF);

    $display("[TB] reset during WAIT");
    delay[1] = -1;
    @(negedge clk);
    wbs_if.wbs_cyc_i = 1'b1;
    wbs_if.wbs_stb_i = 1'b1;
    wbs_if.wbs_adr_i = 32'h3001_7777;
    @(negedge clk);
    check_output("pre_reset_strobe", 32'(all_stb), 32'(M_T1));
    rst_n = 1'b0;
    #1;
    check_output("async_rst_strobes", 32'(all_stb), 32'h0);
    check_output("async_rst_ack", 32'(wbs_if.wbs_ack_o), 32'h0);
    check_output("async_rst_adr_truncated", adr_trunc, 32'h0);
    check_output("async_rst_err_count", 32'(err_count), 32'h0);
    wbs_if.wbs_cyc_i = 1'b0;
    wbs_if.wbs_stb_i = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_output("post_reset_strobes", 32'(all_stb), 32'h0);

    $display("[TB] recovery after reset");
    delay[1] = 0;
    apply_stimulus(32'h3001_0100, M_T1, 1, TEAM1_D, 1'b0, 2);
    apply_stimulus(32'h3055_0000, 5'b0, 0, 32'h0, 1'b1, 1);

    repeat (5) @(negedge clk);
    check_output("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
